// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified-memory port arbiter.
// Imported by the arbiter top and its starvation counter.
package mem_arb_pkg;

  localparam int ADDR_WIDTH_D   = 32;
  localparam int DATA_WIDTH_D   = 32;
  localparam int MEM_LATENCY_D  = 1;
  localparam int STARVE_LIMIT_D = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_LDR
  } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of CPU grants taken while the loader waits.
// at_limit hands the next grant to the loader.
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign at_limit = (cnt == CW'(LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory between CPU datapath and program loader.
// Each access: one IDLE decision, MEM_LATENCY ACCESS cycles, one DONE ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_D,
  parameter int DATA_WIDTH   = DATA_WIDTH_D,
  parameter int MEM_LATENCY  = MEM_LATENCY_D,
  parameter int STARVE_LIMIT = STARVE_LIMIT_D
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  ldr_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t         state;
  owner_t         owner;
  logic           lat_we;
  logic [LW-1:0]  lat_cnt;
  logic           at_limit;
  logic           ldr_wins;
  logic           grant;
  logic           inc;
  logic           clr;

  assign ldr_wins  = ldr_req & (~cpu_req | at_limit);
  assign grant     = (state == IDLE) & (cpu_req | ldr_req);
  assign inc       = grant & ~ldr_wins & ldr_req;
  assign clr       = (state == IDLE) & (~ldr_req | ldr_wins);
  assign busy      = (state != IDLE);
  assign cpu_stall = cpu_req & ~cpu_ack;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc),
    .clr      (clr),
    .at_limit (at_limit)
  );

  // mem_addr/mem_wdata double as the latched request and hold between accesses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      lat_we    <= 1'b0;
      lat_cnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            owner     <= ldr_wins ? OWN_LDR : OWN_CPU;
            lat_we    <= ldr_wins ? ldr_we : cpu_we;
            mem_we    <= ldr_wins ? ldr_we : cpu_we;
            mem_addr  <= ldr_wins ? ldr_addr : cpu_addr;
            mem_wdata <= ldr_wins ? ldr_wdata : cpu_wdata;
            lat_cnt   <= LW'(MEM_LATENCY - 1);
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_cnt == '0) begin
            if (!lat_we && owner == OWN_CPU) cpu_rdata <= mem_rdata;
            if (!lat_we && owner == OWN_LDR) ldr_rdata <= mem_rdata;
            cpu_ack <= (owner == OWN_CPU);
            ldr_ack <= (owner == OWN_LDR);
            state   <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified instruction/data memory of the multicycle processor between two requesters: the CPU datapath and the program loader, which writes boot images and reads them back. It sits between the requesters and the memory macro. It sequences each access over a fixed read latency and returns a one-cycle acknowledge. It exports a stall so the control FSM can hold its state while the loader owns the memory.

## Interface
- ADDR_WIDTH, 32, memory byte-address width
- DATA_WIDTH, 32, data word width
- MEM_LATENCY, 1, cycles from address presented to mem_rdata valid (≥1)
- STARVE_LIMIT, 4, consecutive CPU grants allowed while loader waits (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req / ldr_req  in  1  access request, held until matching ack
- cpu_we / ldr_we  in  1  1 = write, 0 = read
- cpu_addr / ldr_addr  in  ADDR_WIDTH  access address
- cpu_wdata / ldr_wdata  in  DATA_WIDTH  write data
- cpu_rdata / ldr_rdata  out  DATA_WIDTH  registered read data
- cpu_ack / ldr_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any request is pending, pick the winner and latch owner, we, addr, and wdata, then go to ACCESS. Otherwise stay in IDLE.
- Arbitration: the CPU wins unless ldr_req=1 and starve_cnt == STARVE_LIMIT. A lone requester always wins.
- starve_cnt:
  - +1 on each CPU grant while ldr_req=1.
  - Cleared on a loader grant.
  - Cleared in IDLE when ldr_req=0.
  - Saturates at STARVE_LIMIT.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_we = latched we in the first ACCESS cycle only.
  - A down-counter runs for MEM_LATENCY cycles. In the last ACCESS cycle, a read captures mem_rdata into the owner's rdata register. Then go to DONE.
- Writes use the same MEM_LATENCY duration and leave rdata unchanged.
- DONE: pulse the owner's ack for one cycle, then go to IDLE unconditionally.
- A requester drops req, or presents a new request, on the edge where it samples ack. A req still high in the following IDLE cycle is a new access.
- A req deasserted mid-access does not abort the access. The access completes and ack still pulses.
- rdata registers hold their value until the same requester's next read completes.
- mem_addr and mem_wdata hold their last values in IDLE and DONE. mem_we is 0 in every state except the first ACCESS cycle.

## Timing
- Reset: state=IDLE, starve_cnt=0. All outputs are 0: rdata, ack, mem_addr, mem_wdata, mem_we, busy. cpu_stall = cpu_req.
- Reset asserted mid-ACCESS: mem_we drops asynchronously, no ack is issued, and the access is lost.
- Request sampled in IDLE at cycle 0:
  - ACCESS occupies cycles 1..MEM_LATENCY.
  - ack is high in cycle MEM_LATENCY+1.
  - rdata is valid from that same cycle.
- Throughput is one access per MEM_LATENCY+2 cycles.
- Simultaneous requests in IDLE are resolved in the same cycle. There is no idle bubble beyond the mandatory IDLE state.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, DONE)
  - owner enum (OWN_CPU, OWN_LDR)
  - default parameter constants
- Sub-module arb_starve_counter: a saturating counter with inc, clr, and at_limit.
- Everything else is one FSM with latched request registers.

## Test plan
- Reset with both reqs=0: all outputs 0, busy=0. Release reset: outputs stay 0.
- CPU read, MEM_LATENCY=2, cpu_addr=0x10, mem_rdata=0xDEADBEEF: mem_addr=0x10 in cycles 1–2, mem_we=0, cpu_ack in cycle 3, cpu_rdata=0xDEADBEEF, cpu_stall high in cycles 0–2.
- Loader write to addr 0x40 with data 0x12345678: mem_we high in exactly one cycle with mem_addr=0x40 and mem_wdata=0x12345678, then ldr_ack. ldr_rdata is unchanged.
- Both reqs held continuously with STARVE_LIMIT=4: grant order is C,C,C,C,L,C,C,C,C,L. Each ack is followed by exactly one IDLE cycle.
- Reset asserted in ACCESS cycle 1 of a write: mem_we falls immediately, no ack, state IDLE after release.
- cpu_req dropped in ACCESS: the access completes, cpu_ack pulses once, and no second access starts.
